// File: rtl/scoreboard_register_file.sv
// Scoreboarded register file: multi-port register storage with per-register busy
// tracking, same-cycle write bypass, and a post-reset sweep that zeroes storage.
module scoreboard_register_file #(
  parameter  int unsigned SUPER_SCALAR_WIDTH = 2,
  parameter  int unsigned NUM_REGS           = 32,
  parameter  int unsigned DATA_WIDTH         = 32,
  localparam int unsigned NRP                = 2 * SUPER_SCALAR_WIDTH,
  localparam int unsigned IDX_W              = $clog2(NUM_REGS)
) (
  input  logic                                           clk_in,
  input  logic                                           rst_in,
  output logic                                           ready_out,
  input  logic                                           flush_in,
  input  logic [NRP-1:0][IDX_W-1:0]                      rd_addr_in,
  output logic [NRP-1:0][DATA_WIDTH-1:0]                 rd_data_out,
  output logic [NRP-1:0]                                 rd_busy_out,
  input  logic [SUPER_SCALAR_WIDTH-1:0]                  wr_en_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][IDX_W-1:0]       wr_addr_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][DATA_WIDTH-1:0]  wr_data_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]                  rsv_en_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0][IDX_W-1:0]       rsv_addr_in,
  output logic [NUM_REGS-1:0]                            busy_vec_out
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_clr_cnt;
  logic                    w_init_done;
  logic                    w_run;
  logic [DATA_WIDTH-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0]     r_busy;
  logic [NUM_REGS-1:0]     w_busy_nxt;

  // Register 0 is hardwired and out-of-range indices are dropped
  function automatic logic addr_ok(input logic [IDX_W-1:0] a);
    return (a != '0) && (32'(a) < NUM_REGS);
  endfunction

  assign w_init_done  = (r_clr_cnt == IDX_W'(NUM_REGS - 1));
  assign busy_vec_out = r_busy;

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= ST_INIT;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: leave INIT on the last sweep edge, then stay in RUN
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == ST_INIT) && w_init_done) w_state_nxt = ST_RUN;
  end

  // FSM outputs
  always_comb begin
    w_run     = (r_state == ST_RUN);
    ready_out = w_run;
  end

  // Sweep counter, advances once per INIT edge
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)    r_clr_cnt <= '0;
    else if (!w_run) r_clr_cnt <= r_clr_cnt + IDX_W'(1);
  end

  // Storage: zeroed by the INIT sweep; later ports overwrite earlier ones
  always_ff @(posedge clk_in) begin
    if (!w_run) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      for (int unsigned p = 0; p < SUPER_SCALAR_WIDTH; p++) begin
        if (wr_en_in[p] && addr_ok(wr_addr_in[p])) r_mem[wr_addr_in[p]] <= wr_data_in[p];
      end
    end
  end

  // Busy next state: write clear < reservation set < flush clear
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_run) begin
      for (int unsigned p = 0; p < SUPER_SCALAR_WIDTH; p++) begin
        if (wr_en_in[p] && addr_ok(wr_addr_in[p])) w_busy_nxt[wr_addr_in[p]] = 1'b0;
      end
      for (int unsigned p = 0; p < SUPER_SCALAR_WIDTH; p++) begin
        if (rsv_en_in[p] && addr_ok(rsv_addr_in[p])) w_busy_nxt[rsv_addr_in[p]] = 1'b1;
      end
      if (flush_in) w_busy_nxt = '0;
    end
  end

  // Busy scoreboard register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  // Combinational reads with same-cycle write bypass (highest write port wins)
  always_comb begin
    rd_data_out = '0;
    rd_busy_out = '0;
    for (int unsigned r = 0; r < NRP; r++) begin
      if (w_run && addr_ok(rd_addr_in[r])) begin
        rd_data_out[r] = r_mem[rd_addr_in[r]];
        rd_busy_out[r] = r_busy[rd_addr_in[r]];
        for (int unsigned p = 0; p < SUPER_SCALAR_WIDTH; p++) begin
          if (wr_en_in[p] && (wr_addr_in[p] == rd_addr_in[r])) begin
            rd_data_out[r] = wr_data_in[p];
            rd_busy_out[r] = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Testbench for scoreboard_register_file: directed scenarios plus randomized
// traffic checked against a behavioural register/busy model.
module tb_scoreboard_register_file;

  localparam int unsigned SSW = 2;
  localparam int unsigned NR  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned NRP = 2 * SSW;
  localparam int unsigned IW  = 5;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    ready_out;
  logic                    flush_in;
  logic [NRP-1:0][IW-1:0]  rd_addr_in;
  logic [NRP-1:0][DW-1:0]  rd_data_out;
  logic [NRP-1:0]          rd_busy_out;
  logic [SSW-1:0]          wr_en_in;
  logic [SSW-1:0][IW-1:0]  wr_addr_in;
  logic [SSW-1:0][DW-1:0]  wr_data_in;
  logic [SSW-1:0]          rsv_en_in;
  logic [SSW-1:0][IW-1:0]  rsv_addr_in;
  logic [NR-1:0]           busy_vec_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [DW-1:0] m_mem  [NR];
  bit            m_busy [NR];
  int            m_init_edges;
  bit            m_ready;

  always #5 clk_in = ~clk_in;

  scoreboard_register_file #(
    .SUPER_SCALAR_WIDTH(SSW),
    .NUM_REGS          (NR),
    .DATA_WIDTH        (DW)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ready_out   (ready_out),
    .flush_in    (flush_in),
    .rd_addr_in  (rd_addr_in),
    .rd_data_out (rd_data_out),
    .rd_busy_out (rd_busy_out),
    .wr_en_in    (wr_en_in),
    .wr_addr_in  (wr_addr_in),
    .wr_data_in  (wr_data_in),
    .rsv_en_in   (rsv_en_in),
    .rsv_addr_in (rsv_addr_in),
    .busy_vec_out(busy_vec_out)
  );

  function automatic void model_reset();
    m_init_edges = 0;
    m_ready      = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Expected read result for an address under the current inputs
  function automatic void model_read(input int a, output logic [DW-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (!m_ready || a == 0) return;
    d = m_mem[a];
    b = m_busy[a];
    for (int p = 0; p < SSW; p++) begin
      if (wr_en_in[p] && int'(wr_addr_in[p]) == a) begin
        d = wr_data_in[p];
        b = 1'b0;
      end
    end
  endfunction

  // Advance the model across one rising edge using the current inputs
  function automatic void model_edge();
    bit rsv_hit, wr_hit;
    if (!m_ready) begin
      m_init_edges++;
      if (m_init_edges == NR) m_ready = 1'b1;
      return;
    end
    for (int i = 1; i < NR; i++) begin
      rsv_hit = 1'b0;
      wr_hit  = 1'b0;
      for (int p = 0; p < SSW; p++) begin
        if (rsv_en_in[p] && int'(rsv_addr_in[p]) == i) rsv_hit = 1'b1;
        if (wr_en_in[p]  && int'(wr_addr_in[p])  == i) wr_hit  = 1'b1;
      end
      if (flush_in)     m_busy[i] = 1'b0;
      else if (rsv_hit) m_busy[i] = 1'b1;
      else if (wr_hit)  m_busy[i] = 1'b0;
    end
    for (int p = 0; p < SSW; p++) begin
      if (wr_en_in[p] && wr_addr_in[p] != '0) m_mem[wr_addr_in[p]] = wr_data_in[p];
    end
  endfunction

  function automatic logic [NR-1:0] model_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic drive_idle();
    wr_en_in    = '0;
    wr_addr_in  = '0;
    wr_data_in  = '0;
    rsv_en_in   = '0;
    rsv_addr_in = '0;
    flush_in    = 1'b0;
  endtask

  task automatic test_reset();
    rst_in     = 1'b0;
    rd_addr_in = '0;
    drive_idle();
    repeat (3) @(negedge clk_in);
    #1;
    n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_out); end
    n_checks++; if (busy_vec_out !== '0) begin n_fail++; $display("FAIL reset_busy_vec: got %h expected 0", busy_vec_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    for (int e = 0; e < int'(NR); e++) begin
      wr_en_in    = SSW'($urandom);
      wr_addr_in  = (SSW*IW)'($urandom);
      wr_data_in  = {$urandom, $urandom};
      rsv_en_in   = SSW'($urandom);
      rsv_addr_in = (SSW*IW)'($urandom);
      flush_in    = 1'($urandom);
      rd_addr_in  = {wr_addr_in, 10'($urandom)};
      #1;
      n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL init_ready edge %0d: got %b expected 0", e, ready_out); end
      n_checks++; if (rd_data_out !== '0 || rd_busy_out !== '0) begin n_fail++; $display("FAIL init_read edge %0d: got data %h busy %b expected 0/0", e, rd_data_out, rd_busy_out); end
      tick();
    end
    drive_idle();
    #1;
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL ready_after_sweep: got %b expected 1", ready_out); end
    n_checks++; if (busy_vec_out !== '0) begin n_fail++; $display("FAIL busy_after_sweep: got %h expected 0", busy_vec_out); end
    for (int g = 0; g < 8; g++) begin
      for (int r = 0; r < int'(NRP); r++) rd_addr_in[r] = IW'(g * 4 + r);
      #1;
      for (int r = 0; r < int'(NRP); r++) begin
        n_checks++;
        if (rd_data_out[r] !== '0 || rd_busy_out[r] !== 1'b0) begin
          n_fail++; $display("FAIL swept_reg r%0d: got %h/%b expected 0/0", g * 4 + r, rd_data_out[r], rd_busy_out[r]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    drive_idle();
    rsv_en_in = 2'b01; rsv_addr_in[0] = 5'd5;
    tick();
    drive_idle();
    #1;
    n_checks++; if (busy_vec_out[5] !== 1'b1) begin n_fail++; $display("FAIL bypass_pre_busy: got %b expected 1", busy_vec_out[5]); end
    wr_en_in = 2'b01; wr_addr_in[0] = 5'd5; wr_data_in[0] = 32'hDEAD_BEEF; rd_addr_in[3] = 5'd5;
    #1;
    n_checks++; if (rd_data_out[3] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_data: got %h expected deadbeef", rd_data_out[3]); end
    n_checks++; if (rd_busy_out[3] !== 1'b0) begin n_fail++; $display("FAIL bypass_busy: got %b expected 0", rd_busy_out[3]); end
    tick();
    drive_idle();
    #1;
    n_checks++; if (rd_data_out[3] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stored_data r5: got %h expected deadbeef", rd_data_out[3]); end
    n_checks++; if (busy_vec_out[5] !== 1'b0) begin n_fail++; $display("FAIL write_clears_busy r5: got %b expected 0", busy_vec_out[5]); end
  endtask

  task automatic test_conflict();
    drive_idle();
    wr_en_in = 2'b11; wr_addr_in[0] = 5'd7; wr_addr_in[1] = 5'd7;
    wr_data_in[0] = 32'h11; wr_data_in[1] = 32'h22; rd_addr_in[0] = 5'd7;
    #1;
    n_checks++; if (rd_data_out[0] !== 32'h22) begin n_fail++; $display("FAIL conflict_bypass: got %h expected 22", rd_data_out[0]); end
    tick();
    drive_idle();
    #1;
    n_checks++; if (rd_data_out[0] !== 32'h22) begin n_fail++; $display("FAIL conflict_stored: got %h expected 22", rd_data_out[0]); end
  endtask

  task automatic test_reserve();
    drive_idle();
    rsv_en_in = 2'b10; rsv_addr_in[1] = 5'd9; rd_addr_in[1] = 5'd9;
    #1;
    n_checks++; if (rd_busy_out[1] !== 1'b0) begin n_fail++; $display("FAIL rsv_same_cycle_read: got %b expected 0", rd_busy_out[1]); end
    tick();
    drive_idle();
    #1;
    n_checks++; if (busy_vec_out[9] !== 1'b1) begin n_fail++; $display("FAIL rsv_sets_busy: got %b expected 1", busy_vec_out[9]); end
    n_checks++; if (rd_busy_out[1] !== 1'b1) begin n_fail++; $display("FAIL rsv_read_busy: got %b expected 1", rd_busy_out[1]); end
    wr_en_in = 2'b01; wr_addr_in[0] = 5'd9; wr_data_in[0] = 32'h99;
    rsv_en_in = 2'b10; rsv_addr_in[1] = 5'd9;
    tick();
    drive_idle();
    #1;
    n_checks++; if (busy_vec_out[9] !== 1'b1) begin n_fail++; $display("FAIL rsv_beats_write: got %b expected 1", busy_vec_out[9]); end
    n_checks++; if (rd_data_out[1] !== 32'h99) begin n_fail++; $display("FAIL rsv_write_data: got %h expected 99", rd_data_out[1]); end
    wr_en_in = 2'b10; wr_addr_in[1] = 5'd9; wr_data_in[1] = 32'h9A;
    tick();
    drive_idle();
    #1;
    n_checks++; if (busy_vec_out[9] !== 1'b0) begin n_fail++; $display("FAIL write_only_clears: got %b expected 0", busy_vec_out[9]); end
    rsv_en_in = 2'b11; rsv_addr_in[0] = 5'd12; rsv_addr_in[1] = 5'd12;
    tick();
    drive_idle();
    #1;
    n_checks++; if (busy_vec_out !== model_busy_vec()) begin n_fail++; $display("FAIL dual_rsv_vec: got %h expected %h", busy_vec_out, model_busy_vec()); end
  endtask

  task automatic test_flush();
    drive_idle();
    wr_en_in = 2'b11; wr_addr_in[0] = 5'd3; wr_addr_in[1] = 5'd4;
    wr_data_in[0] = 32'h33; wr_data_in[1] = 32'h44;
    tick();
    drive_idle();
    rsv_en_in = 2'b11; rsv_addr_in[0] = 5'd3; rsv_addr_in[1] = 5'd4;
    tick();
    drive_idle();
    #1;
    n_checks++; if (busy_vec_out[4:3] !== 2'b11) begin n_fail++; $display("FAIL pre_flush_busy: got %b expected 11", busy_vec_out[4:3]); end
    flush_in = 1'b1; rsv_en_in = 2'b01; rsv_addr_in[0] = 5'd3;
    wr_en_in = 2'b10; wr_addr_in[1] = 5'd10; wr_data_in[1] = 32'hABCD;
    tick();
    drive_idle();
    rd_addr_in[0] = 5'd3; rd_addr_in[1] = 5'd4; rd_addr_in[2] = 5'd10;
    #1;
    n_checks++; if (busy_vec_out !== '0) begin n_fail++; $display("FAIL flush_busy_vec: got %h expected 0", busy_vec_out); end
    n_checks++; if (rd_data_out[0] !== 32'h33 || rd_data_out[1] !== 32'h44) begin n_fail++; $display("FAIL flush_keeps_data: got %h %h expected 33 44", rd_data_out[0], rd_data_out[1]); end
    n_checks++; if (rd_data_out[2] !== 32'hABCD) begin n_fail++; $display("FAIL flush_cycle_write: got %h expected abcd", rd_data_out[2]); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_d;
    logic          exp_b;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < int'(SSW); p++) begin
        wr_en_in[p]    = 1'($urandom);
        wr_addr_in[p]  = IW'($urandom_range(0, 7));
        wr_data_in[p]  = $urandom;
        rsv_en_in[p]   = 1'($urandom);
        rsv_addr_in[p] = ($urandom_range(0, 3) == 0) ? IW'($urandom) : IW'($urandom_range(0, 7));
      end
      flush_in = ($urandom_range(0, 19) == 0);
      for (int r = 0; r < int'(NRP); r++)
        rd_addr_in[r] = ($urandom_range(0, 2) == 0) ? wr_addr_in[r % SSW] : IW'($urandom_range(0, 9));
      #1;
      for (int r = 0; r < int'(NRP); r++) begin
        model_read(int'(rd_addr_in[r]), exp_d, exp_b);
        n_checks++;
        if (rd_data_out[r] !== exp_d || rd_busy_out[r] !== exp_b) begin
          n_fail++; $display("FAIL rand_read c%0d port%0d r%0d: got %h/%b expected %h/%b", c, r, rd_addr_in[r], rd_data_out[r], rd_busy_out[r], exp_d, exp_b);
        end
      end
      tick();
      #1;
      n_checks++;
      if (busy_vec_out !== model_busy_vec()) begin
        n_fail++; $display("FAIL rand_busy_vec c%0d: got %h expected %h", c, busy_vec_out, model_busy_vec());
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_run();
    drive_idle();
    wr_en_in = 2'b11; wr_addr_in[0] = 5'd0; wr_data_in[0] = 32'hFFFF;
    wr_addr_in[1] = 5'd5; wr_data_in[1] = 32'h5555;
    rsv_en_in = 2'b11; rsv_addr_in[0] = 5'd0; rsv_addr_in[1] = 5'd6;
    rd_addr_in[0] = 5'd0; rd_addr_in[1] = 5'd5;
    #1;
    n_checks++; if (rd_data_out[0] !== '0 || rd_busy_out[0] !== 1'b0) begin n_fail++; $display("FAIL r0_hardwired: got %h/%b expected 0/0", rd_data_out[0], rd_busy_out[0]); end
    #1;
    rst_in = 1'b0;
    #1;
    n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b expected 0", ready_out); end
    n_checks++; if (busy_vec_out !== '0) begin n_fail++; $display("FAIL async_reset_busy: got %h expected 0", busy_vec_out); end
    n_checks++; if (rd_data_out[1] !== '0) begin n_fail++; $display("FAIL reset_read_zero: got %h expected 0", rd_data_out[1]); end
    @(posedge clk_in);
    @(negedge clk_in);
    drive_idle();
    rst_in = 1'b1;
    model_reset();
    for (int e = 0; e < int'(NR); e++) begin
      #1;
      n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL resweep_ready edge %0d: got %b expected 0", e, ready_out); end
      tick();
    end
    rd_addr_in[0] = 5'd0; rd_addr_in[1] = 5'd5; rd_addr_in[2] = 5'd9; rd_addr_in[3] = 5'd7;
    #1;
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL resweep_ready_high: got %b expected 1", ready_out); end
    n_checks++; if (rd_data_out !== '0 || rd_busy_out !== '0) begin n_fail++; $display("FAIL resweep_cleared: got %h/%b expected 0", rd_data_out, rd_busy_out); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bypass();
    test_conflict();
    test_reserve();
    test_flush();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter SUPER_SCALAR_WIDTH, default 2: number of write ports and reserve ports; read ports = 2*SUPER_SCALAR_WIDTH (NRP).
REQ-003 Parameter NUM_REGS, default 32: register count; localparam IDX_W = $clog2(NUM_REGS).
REQ-004 Parameter DATA_WIDTH, default 32: register width.
REQ-005 clk_in  input  1  clock, all state on rising edge.
REQ-006 rst_in  input  1  asynchronous active-low reset.
REQ-007 ready_out  output  1  high when initialisation is complete and the file accepts traffic.
REQ-008 flush_in  input  1  clear all busy bits.
REQ-009 rd_addr_in  input  NRP x IDX_W  read addresses.
REQ-010 rd_data_out  output  NRP x DATA_WIDTH  read data.
REQ-011 rd_busy_out  output  NRP  read register has an outstanding producer.
REQ-012 wr_en_in / wr_addr_in / wr_data_in  input  SUPER_SCALAR_WIDTH x (1 / IDX_W / DATA_WIDTH)  writeback ports.
REQ-013 rsv_en_in / rsv_addr_in  input  SUPER_SCALAR_WIDTH x (1 / IDX_W)  destination reservation ports (issue).
REQ-014 busy_vec_out  output  NUM_REGS  registered scoreboard, bit i = register i busy.

Function
REQ-015 Two-state FSM: INIT and RUN, with an IDX_W-bit clear counter.
REQ-016 INIT: each edge writes 0 to entry[counter] and increments counter; the edge with counter==NUM_REGS-1 moves to RUN, so ready_out rises after exactly NUM_REGS edges.
REQ-017 In INIT: rd_data_out=0, rd_busy_out=0; wr_en_in, rsv_en_in and flush_in are ignored.
REQ-018 RUN: FSM stays in RUN until reset; ready_out=1.
REQ-019 Reads are combinational (0-cycle latency).
REQ-020 Register 0 reads 0 with busy 0; writes and reservations to register 0 are ignored.
REQ-021 Bypass: if any enabled write port targets rd_addr (nonzero) in the same cycle, rd_data_out returns that port's wr_data_in and rd_busy_out=0.
REQ-022 Otherwise rd_data_out = stored entry, rd_busy_out = busy bit; same-cycle reservations do not affect read outputs.
REQ-023 Write conflict: several enabled write ports with one address -> highest port index wins, for both storage and bypass.
REQ-024 Write stores wr_data_in at the edge and clears busy[addr] unless that register is reserved in the same cycle.
REQ-025 Reservation sets busy[addr] at the edge; several ports reserving one address set it once, no error.
REQ-026 Busy priority per register, highest first: flush_in (clear), reservation (set), write (clear), hold.
REQ-027 flush_in never alters stored data; same-cycle writes still update storage.
REQ-028 Write to a register that is not busy is accepted normally (busy stays 0).
REQ-029 Addresses >= NUM_REGS (non-power-of-two NUM_REGS) are ignored for write/reserve and read 0.

Reset
REQ-030 rst_in low asynchronously forces: state INIT, counter 0, ready_out 0, busy_vec_out all 0; stored data is cleared by the INIT sweep, not by reset.
REQ-031 Reset asserted mid-INIT or mid-RUN restarts the full NUM_REGS-cycle INIT sweep; in-flight writes in that cycle are lost.

Verification
REQ-032 Release reset, default params -> ready_out 0 for 32 edges, 1 after the 32nd; all 32 registers read 0.
REQ-033 RUN: write r5=0xDEADBEEF on port 0 while reading r5 on port 3 -> same cycle rd_data_out[3]=0xDEADBEEF, busy 0; next cycle stored value equal.
REQ-034 Ports 0 and 1 both write r7 (0x11, 0x22) -> r7 reads 0x22 same cycle and after.
REQ-035 Reserve r9 -> busy_vec_out[9]=1 next cycle; write r9 with reserve r9 same cycle -> stays 1; later write only -> 0.
REQ-036 Busy r3 and r4, assert flush_in with reserve r3 -> busy_vec_out=0 next cycle; data unchanged.
REQ-037 Write r0=0xFFFF, reserve r0, and assert reset during RUN -> r0 reads 0 busy 0; after reset, ready_out low for 32 edges again.
